// File: rtl/fractal_axi_master_if.sv
// Command/response and AXI4-Lite signal bundle for fractal_axi_master.
// master modport is the engine side, slave modport the sequencer/bus side.
interface fractal_axi_master_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output AWADDR, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARPROT, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  AWADDR, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARPROT, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/fractal_axi_master.sv
// AXI4-Lite master: one command in, one AXI transaction, one response out.
// Define FRACTAL_AXI_MASTER_TIMEOUT_EN to bound the B/R wait by TIMEOUT_CYCLES.
module fractal_axi_master #(
    parameter int M_AXI_DATA_WIDTH = 32,
    parameter int M_AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input logic M_AXI_ACLK,
    input logic M_AXI_ARESETN,
    fractal_axi_master_if.master bus
);
    localparam int DW = M_AXI_DATA_WIDTH;
    localparam int AW = M_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        RSP
    } state_t;

    state_t          state_q, state_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic            aw_ok, w_ok;

    // A channel is finished once its VALID is already low or completes now.
    assign aw_ok = !awvalid_q || bus.AWREADY;
    assign w_ok  = !wvalid_q || bus.WREADY;

`ifdef FRACTAL_AXI_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;
    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
`ifdef FRACTAL_AXI_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    if (bus.cmd_write) begin
                        wdata_d   = bus.cmd_wdata;
                        wstrb_d   = bus.cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            WRITE: begin
                if (bus.AWREADY) awvalid_d = 1'b0;
                if (bus.WREADY)  wvalid_d  = 1'b0;
                if (aw_ok && w_ok) state_d = WRESP;
            end
            WRESP: begin
                if (bus.BVALID) begin
                    resp_d  = bus.BRESP;
                    rdata_d = '0;
                    state_d = RSP;
                end else begin
`ifdef FRACTAL_AXI_MASTER_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
                    if (tmo) begin
                        resp_d  = 2'b10;
                        rdata_d = DW'(32'hDEAD_BEEF);
                        state_d = RSP;
                    end
`endif
                end
            end
            READ: begin
                if (bus.ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (bus.RVALID) begin
                    resp_d  = bus.RRESP;
                    rdata_d = bus.RDATA;
                    state_d = RSP;
                end else begin
`ifdef FRACTAL_AXI_MASTER_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
                    if (tmo) begin
                        resp_d  = 2'b10;
                        rdata_d = DW'(32'hDEAD_BEEF);
                        state_d = RSP;
                    end
`endif
                end
            end
            RSP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
`ifdef FRACTAL_AXI_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
`ifdef FRACTAL_AXI_MASTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // B and R are always accepted so stale responses drain harmlessly.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RSP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_resp  = resp_q;
    assign bus.AWADDR    = addr_q;
    assign bus.AWPROT    = 3'b000;
    assign bus.AWVALID   = awvalid_q;
    assign bus.WDATA     = wdata_q;
    assign bus.WSTRB     = wstrb_q;
    assign bus.WVALID    = wvalid_q;
    assign bus.BREADY    = 1'b1;
    assign bus.ARADDR    = addr_q;
    assign bus.ARPROT    = 3'b000;
    assign bus.ARVALID   = arvalid_q;
    assign bus.RREADY    = 1'b1;
endmodule

// File: tb/tb_fractal_axi_master.sv
// Bench for fractal_axi_master: scripted AXI4-Lite slave, vector table,
// random commands against a register-file model, reset and wait corners.
module tb_fractal_axi_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_rst_n = 1'b0;
    always #5 clk = ~clk;

    fractal_axi_master_if #(.DW(32), .AW(4)) bus ();

    fractal_axi_master #(
        .M_AXI_DATA_WIDTH(32),
        .M_AXI_ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESETN(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit b_never = 1'b0;
    logic [1:0] bresp_k = 2'b00, rresp_k = 2'b00;

    logic [31:0] sreg [4];
    logic        aw_got, w_got, b_pend, r_pend;
    logic [3:0]  aw_a, last_araddr;
    logic [31:0] w_d, r_d;
    logic [3:0]  w_s;
    int aw_ctr, w_ctr, ar_ctr, b_ctr, r_ctr;
    int aw_cnt, w_cnt, b_cnt, ar_cnt;

    logic aw_hs, w_hs, ar_hs, aw_have, w_have;
    logic [3:0]  wa, ws;
    logic [31:0] wd;
    assign aw_hs   = bus.AWVALID && bus.AWREADY;
    assign w_hs    = bus.WVALID && bus.WREADY;
    assign ar_hs   = bus.ARVALID && bus.ARREADY;
    assign aw_have = aw_got || aw_hs;
    assign w_have  = w_got || w_hs;
    assign wa      = aw_hs ? bus.AWADDR : aw_a;
    assign wd      = w_hs ? bus.WDATA : w_d;
    assign ws      = w_hs ? bus.WSTRB : w_s;

    assign bus.AWREADY = bus.AWVALID && !aw_got && (aw_ctr >= aw_wait);
    assign bus.WREADY  = bus.WVALID && !w_got && (w_ctr >= w_wait);
    assign bus.ARREADY = bus.ARVALID && !r_pend && (ar_ctr >= ar_wait);
    assign bus.BVALID  = b_pend && !b_never && (b_ctr >= b_wait);
    assign bus.BRESP   = bresp_k;
    assign bus.RVALID  = r_pend && (r_ctr >= r_wait);
    assign bus.RDATA   = r_d;
    assign bus.RRESP   = rresp_k;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < 4; i++) sreg[i] <= '0;
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
            aw_a <= 0; w_d <= 0; w_s <= 0; r_d <= 0; last_araddr <= 0;
            aw_ctr <= 0; w_ctr <= 0; ar_ctr <= 0; b_ctr <= 0; r_ctr <= 0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0;
        end else begin
            aw_ctr <= (bus.AWVALID && !bus.AWREADY) ? aw_ctr + 1 : 0;
            w_ctr  <= (bus.WVALID && !bus.WREADY) ? w_ctr + 1 : 0;
            ar_ctr <= (bus.ARVALID && !bus.ARREADY) ? ar_ctr + 1 : 0;
            aw_cnt <= aw_cnt + int'(aw_hs);
            w_cnt  <= w_cnt + int'(w_hs);
            if (b_pend) begin
                if (bus.BVALID && bus.BREADY) begin
                    b_pend <= 0;
                    b_cnt  <= b_cnt + 1;
                end else if (!bus.BVALID) begin
                    b_ctr <= b_ctr + 1;
                end
            end
            if (aw_have && w_have && !b_pend) begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) sreg[wa[3:2]][8*i +: 8] <= wd[8*i +: 8];
                b_pend <= 1; b_ctr <= 0; aw_got <= 0; w_got <= 0;
            end else begin
                if (aw_hs) begin aw_got <= 1; aw_a <= bus.AWADDR; end
                if (w_hs) begin w_got <= 1; w_d <= bus.WDATA; w_s <= bus.WSTRB; end
            end
            if (ar_hs) begin
                r_pend <= 1; r_ctr <= 0;
                r_d <= sreg[bus.ARADDR[3:2]];
                last_araddr <= bus.ARADDR;
                ar_cnt <= ar_cnt + 1;
            end
            if (r_pend) begin
                if (bus.RVALID && bus.RREADY) r_pend <= 0;
                else if (!bus.RVALID) r_ctr <= r_ctr + 1;
            end
        end
    end

    // VALID must hold with a stable payload while the slave stalls it.
    logic pv_aw = 0, pv_w = 0, pv_ar = 0;
    logic [3:0]  p_awaddr, p_araddr, p_wstrb;
    logic [31:0] p_wdata;
    int proto_err = 0;
    always_ff @(posedge clk) begin
        proto_err <= proto_err
            + int'(rst_n && pv_aw && (!bus.AWVALID || bus.AWADDR != p_awaddr))
            + int'(rst_n && pv_w && (!bus.WVALID || bus.WDATA != p_wdata
                                     || bus.WSTRB != p_wstrb))
            + int'(rst_n && pv_ar && (!bus.ARVALID || bus.ARADDR != p_araddr))
            + int'(rst_n && (bus.AWPROT != 3'b000 || bus.ARPROT != 3'b000));
        pv_aw <= rst_n && bus.AWVALID && !bus.AWREADY;
        pv_w  <= rst_n && bus.WVALID && !bus.WREADY;
        pv_ar <= rst_n && bus.ARVALID && !bus.ARREADY;
        p_awaddr <= bus.AWADDR;
        p_wdata  <= bus.WDATA;
        p_wstrb  <= bus.WSTRB;
        p_araddr <= bus.ARADDR;
    end

    logic [31:0] mem [4];

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic model_apply(input bit wr, input logic [3:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        if (wr)
            for (int i = 0; i < 4; i++)
                if (s[i]) mem[a[3:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic issue(input bit wr, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wstrb = s;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound, output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_arrives", bus.rsp_valid, 1);
    endtask

    task automatic finish_rsp(input int stall);
        logic [31:0] rd;
        logic [1:0]  rr;
        int bad;
        rd = bus.rsp_rdata;
        rr = bus.rsp_resp;
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_rdata != rd || bus.rsp_resp != rr
                || bus.cmd_ready || bus.AWVALID || bus.WVALID || bus.ARVALID)
                bad++;
        end
        if (stall > 0) check("rsp_stall_stable", bad, 0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_release", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        int          aw, w, b, ar, r;
        logic [1:0]  rk;
        int          stall;
        logic [31:0] e_rd;
        logic [1:0]  e_rr;
        int          e_lat;
    } vec_t;

    vec_t tv [10];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        int lat, bad;
        int a0, w0, b0, r0;

        tv[0] = '{1, 4'h4, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0, 2'd0, 3};
        tv[1] = '{0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h1234_5678, 2'd0, 3};
        tv[2] = '{1, 4'h8, 32'hAABB_CCDD, 4'h5, 0, 5, 0, 0, 0, 2'd0, 0, 32'h0, 2'd0, 8};
        tv[3] = '{0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 10, 32'h00BB_00DD, 2'd0, 3};
        tv[4] = '{1, 4'hC, 32'hCAFE_F00D, 4'hF, 3, 0, 0, 0, 0, 2'd3, 0, 32'h0, 2'd3, 6};
        tv[5] = '{0, 4'h5, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h1234_5678, 2'd0, 3};
        tv[6] = '{0, 4'hC, 32'h0, 4'h0, 0, 0, 0, 2, 3, 2'd2, 0, 32'hCAFE_F00D, 2'd2, 8};
        tv[7] = '{1, 4'h0, 32'h1111_1111, 4'hF, 0, 0, 2, 0, 0, 2'd0, 0, 32'h0, 2'd0, 5};
        tv[8] = '{1, 4'h4, 32'hFFFF_0000, 4'hC, 1, 1, 0, 0, 0, 2'd0, 0, 32'h0, 2'd0, 4};
        tv[9] = '{0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 32'hFFFF_5678, 2'd0, 3};

        for (int i = 0; i < 4; i++) mem[i] = '0;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
        bus.cmd_wdata = 0; bus.cmd_wstrb = 0; bus.rsp_ready = 0;

        #3;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata}, 0);
        check("rst_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID}, 0);
        check("rst_readys", {bus.BREADY, bus.RREADY}, 2'b11);
        check("rst_regs", {bus.AWADDR, bus.WDATA, bus.WSTRB, bus.AWPROT}, 0);
        @(negedge clk);
        rst_n = 1; s_rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            aw_wait = tv[i].aw; w_wait = tv[i].w; b_wait = tv[i].b;
            ar_wait = tv[i].ar; r_wait = tv[i].r;
            bresp_k = tv[i].rk; rresp_k = tv[i].rk;
            a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; r0 = ar_cnt;
            issue(tv[i].wr, tv[i].a, tv[i].d, tv[i].s);
            wait_rsp(200, lat);
            check("tv_rdata", bus.rsp_rdata, tv[i].e_rd);
            check("tv_resp", bus.rsp_resp, tv[i].e_rr);
            check("tv_latency", lat, tv[i].e_lat);
            finish_rsp(tv[i].stall);
            model_apply(tv[i].wr, tv[i].a, tv[i].d, tv[i].s);
            check("tv_hs_counts",
                  {aw_cnt - a0, w_cnt - w0, b_cnt - b0, ar_cnt - r0},
                  tv[i].wr ? {32'd1, 32'd1, 32'd1, 32'd0}
                           : {32'd0, 32'd0, 32'd0, 32'd1});
            if (!tv[i].wr) check("tv_araddr", last_araddr, tv[i].a);
        end

        for (int k = 0; k < 40; k++) begin
            bit          wr;
            logic [3:0]  a, s;
            logic [31:0] d, e_rd;
            logic [1:0]  rk;
            int          e_lat, stall;
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            rk = 2'($urandom_range(0, 3));
            aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
            b_wait = $urandom_range(0, 3); ar_wait = $urandom_range(0, 3);
            r_wait = $urandom_range(0, 3);
            stall = $urandom_range(0, 2);
            bresp_k = rk; rresp_k = rk;
            if (wr) begin
                e_rd  = 0;
                e_lat = 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
            end else begin
                e_rd  = mem[a[3:2]];
                e_lat = 3 + ar_wait + r_wait;
            end
            issue(wr, a, d, s);
            wait_rsp(200, lat);
            check("rnd_rdata", bus.rsp_rdata, e_rd);
            check("rnd_resp", bus.rsp_resp, rk);
            check("rnd_latency", lat, e_lat);
            finish_rsp(stall);
            model_apply(wr, a, d, s);
        end
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        bresp_k = 0; rresp_k = 0;

        b_never = 1;
        issue(1, 4'h0, 32'h5A5A_5A5A, 4'hF);
        @(negedge clk);
        check("wresp_state", {bus.AWVALID, bus.WVALID, bus.cmd_ready}, 0);
        rst_n = 0;
        #1;
        check("rst_wresp_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID}, 0);
        check("rst_wresp_ready", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        @(negedge clk);
        rst_n = 1;
        b_never = 0;
        model_apply(1, 4'h0, 32'h5A5A_5A5A, 4'hF);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.cmd_ready) bad++;
        end
        check("rst_no_response", bad, 0);
        issue(0, 4'h0, 0, 0);
        wait_rsp(200, lat);
        check("post_rst_rdata", bus.rsp_rdata, mem[0]);
        check("post_rst_latency", lat, 3);
        finish_rsp(0);

        aw_wait = 50; w_wait = 50;
        issue(1, 4'h4, 32'h0BAD_0BAD, 4'hF);
        check("write_valids", {bus.AWVALID, bus.WVALID}, 2'b11);
        #2;
        rst_n = 0;
        #1;
        check("async_rst_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID}, 0);
        @(negedge clk);
        rst_n = 1;
        aw_wait = 0; w_wait = 0;
        issue(0, 4'h4, 0, 0);
        wait_rsp(200, lat);
        check("post_async_rdata", bus.rsp_rdata, mem[1]);
        finish_rsp(0);

        b_never = 1;
        issue(1, 4'h8, 32'h7777_8888, 4'hF);
        model_apply(1, 4'h8, 32'h7777_8888, 4'hF);
`ifdef FRACTAL_AXI_MASTER_TIMEOUT_EN
        wait_rsp(200, lat);
        check("tmo_latency", lat, 18);
        check("tmo_resp", bus.rsp_resp, 2'b10);
        check("tmo_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        finish_rsp(0);
        b_never = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.cmd_ready) bad++;
        end
        check("tmo_stale_dropped", bad, 0);
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.cmd_ready) bad++;
        end
        check("still_waiting", bad, 0);
        b_never = 0;
        wait_rsp(50, lat);
        check("late_b_resp", {bus.rsp_resp, bus.rsp_rdata}, 0);
        finish_rsp(0);
`endif
        issue(0, 4'h8, 0, 0);
        wait_rsp(200, lat);
        check("final_rdata", bus.rsp_rdata, mem[2]);
        finish_rsp(0);

        @(negedge clk);
        check("protocol_errors", proto_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
